// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller and its MDU busy counter.
package pipe_stall_ctrl_pkg;

    // Tuse value meaning "this source register is not read"
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Architectural register zero: never a real dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default MDU latencies, shared so the controller and MDU agree
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W_DEF       = 4;

endpackage

// File: rtl/pipe_stall_ctrl_md_busy_cnt.sv
// Multiply/divide unit occupancy countdown; md_busy is high while the count is nonzero.
module md_busy_cnt
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    logic [CNT_W-1:0] md_cnt;

    // Load on a new MDU op (overrides any count in progress), otherwise count down to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (md_start) begin
            md_cnt <= md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    assign md_busy = (md_cnt != '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: Tuse/Tnew compare, MDU
// occupancy interlock, and a saturating stall-cycle counter.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs_addr,
    input  logic [4:0]  d_rt_addr,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic [4:0]  e_wa,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  m_tnew,
    input  logic        md_start,
    input  logic        md_is_div,
    output logic        pc_write,
    output logic        fd_en,
    output logic        de_flush,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic        rs_hazard;
    logic        rt_hazard;
    logic        md_hazard;
    logic [31:0] stall_cnt_q;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .md_busy   (md_busy)
    );

    // A source stalls when a producer in E or M will not have its result ready by the time D needs it
    always_comb begin
        rs_hazard = (d_rs_addr != REG_ZERO) &&
                    (((d_rs_addr == e_wa) && (d_tuse_rs < e_tnew)) ||
                     ((d_rs_addr == m_wa) && (d_tuse_rs < m_tnew)));
        rt_hazard = (d_rt_addr != REG_ZERO) &&
                    (((d_rt_addr == e_wa) && (d_tuse_rt < e_tnew)) ||
                     ((d_rt_addr == m_wa) && (d_tuse_rt < m_tnew)));
        // md_start covers the issue cycle, before the countdown has been loaded
        md_hazard = d_is_md && (md_busy || md_start);
        stall     = rs_hazard || rt_hazard || md_hazard;
        pc_write  = ~stall;
        fd_en     = ~stall;
        de_flush  = stall;
    end

    // Count stalled cycles, saturating at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: expected outputs are queued as each
// cycle's stimulus is applied and compared when the outputs settle.
module tb_pipe_stall_ctrl;
    import pipe_stall_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs_addr, d_rt_addr, e_wa, m_wa;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_is_md, md_start, md_is_div;
    logic        pc_write, fd_en, de_flush, stall, md_busy;
    logic [31:0] stall_cnt;

    typedef struct {
        string       tag;
        logic        stall;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_cnt  = '0;

    pipe_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs_addr (d_rs_addr),
        .d_rt_addr (d_rt_addr),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_is_md   (d_is_md),
        .e_wa      (e_wa),
        .e_tnew    (e_tnew),
        .m_wa      (m_wa),
        .m_tnew    (m_tnew),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .pc_write  (pc_write),
        .fd_en     (fd_en),
        .de_flush  (de_flush),
        .stall     (stall),
        .md_busy   (md_busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        d_rs_addr = '0; d_rt_addr = '0;
        d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE;
        d_is_md = 1'b0;
        e_wa = '0; e_tnew = '0; m_wa = '0; m_tnew = '0;
        md_start = 1'b0; md_is_div = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied: queue, compare, advance one cycle
    task automatic step(input string tag, input logic exp_stall, input logic exp_busy);
        exp_t e;
        e.tag = tag; e.stall = exp_stall; e.busy = exp_busy; e.cnt = exp_cnt;
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            check_val({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val({e.tag, ".stall"},     {31'd0, stall},    {31'd0, e.stall});
            check_val({e.tag, ".pc_write"},  {31'd0, pc_write}, {31'd0, ~e.stall});
            check_val({e.tag, ".fd_en"},     {31'd0, fd_en},    {31'd0, ~e.stall});
            check_val({e.tag, ".de_flush"},  {31'd0, de_flush}, {31'd0, e.stall});
            check_val({e.tag, ".md_busy"},   {31'd0, md_busy},  {31'd0, e.busy});
            check_val({e.tag, ".stall_cnt"}, stall_cnt,         e.cnt);
        end
        @(posedge clk);
        if (exp_stall && reset && (exp_cnt != 32'hFFFF_FFFF)) exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        step("reset_state", 1'b0, 1'b0);
        reset = 1'b1;
        step("idle", 1'b0, 1'b0);

        // Load-use against E, then against M, then M result ready
        d_rs_addr = 5'd5; d_tuse_rs = 2'd0; e_wa = 5'd5; e_tnew = 2'd2;
        step("lu_e", 1'b1, 1'b0);
        m_wa = 5'd5; m_tnew = 2'd1; e_wa = 5'd0;
        step("lu_m", 1'b1, 1'b0);
        m_tnew = 2'd0;
        step("lu_m_ready", 1'b0, 1'b0);

        // Register zero and unused source
        idle_inputs();
        d_rt_addr = 5'd0; d_tuse_rt = 2'd0; e_wa = 5'd0; e_tnew = 2'd2;
        step("zero_reg", 1'b0, 1'b0);
        idle_inputs();
        d_rs_addr = 5'd5; d_tuse_rs = TUSE_NONE; e_wa = 5'd5; e_tnew = 2'd2;
        step("tuse_none", 1'b0, 1'b0);

        // rt path: Tuse < Tnew stalls, Tuse == Tnew does not
        idle_inputs();
        d_rt_addr = 5'd7; d_tuse_rt = 2'd1; m_wa = 5'd7; m_tnew = 2'd2;
        step("rt_m", 1'b1, 1'b0);
        m_wa = 5'd0; e_wa = 5'd7; e_tnew = 2'd1;
        step("rt_e_equal", 1'b0, 1'b0);

        // Divide occupancy with an MDU instr waiting in D
        idle_inputs();
        d_is_md = 1'b1; md_start = 1'b1; md_is_div = 1'b1;
        step("div_start", 1'b1, 1'b0);
        md_start = 1'b0;
        for (int i = 0; i < 10; i++) step("div_busy", 1'b1, 1'b1);
        step("div_done", 1'b0, 1'b0);

        // Multiply occupancy
        md_start = 1'b1; md_is_div = 1'b0;
        step("mul_start", 1'b1, 1'b0);
        md_start = 1'b0;
        for (int i = 0; i < 5; i++) step("mul_busy", 1'b1, 1'b1);
        step("mul_done", 1'b0, 1'b0);

        // Non-MDU instr proceeds while the MDU is busy
        d_is_md = 1'b0; md_start = 1'b1; md_is_div = 1'b0;
        step("nonmd_start", 1'b0, 1'b0);
        md_start = 1'b0;
        for (int i = 0; i < 5; i++) step("nonmd_busy", 1'b0, 1'b1);
        step("nonmd_done", 1'b0, 1'b0);

        // New multiply reloads over a divide in progress
        d_is_md = 1'b1; md_start = 1'b1; md_is_div = 1'b1;
        step("ovr_div_start", 1'b1, 1'b0);
        md_start = 1'b0;
        for (int i = 0; i < 2; i++) step("ovr_div_busy", 1'b1, 1'b1);
        md_start = 1'b1; md_is_div = 1'b0;
        step("ovr_mul_start", 1'b1, 1'b1);
        md_start = 1'b0;
        for (int i = 0; i < 5; i++) step("ovr_mul_busy", 1'b1, 1'b1);
        step("ovr_done", 1'b0, 1'b0);

        // Reset mid-divide clears state without waiting for a clock
        d_is_md = 1'b0; md_start = 1'b1; md_is_div = 1'b1;
        step("rst_div_start", 1'b0, 1'b0);
        md_start = 1'b0;
        for (int i = 0; i < 3; i++) step("rst_div_busy", 1'b0, 1'b1);
        reset = 1'b0;
        exp_cnt = '0;
        step("rst_async", 1'b0, 1'b0);
        reset = 1'b1;
        step("rst_release", 1'b0, 1'b0);
        step("rst_after", 1'b0, 1'b0);

        // Saturation of the stall counter
        idle_inputs();
        d_rs_addr = 5'd9; d_tuse_rs = 2'd0; e_wa = 5'd9; e_tnew = 2'd1;
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        exp_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step("sat", 1'b1, 1'b0);
        idle_inputs();
        step("sat_hold", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
